// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state encoding, defaults and circular index helper for fifo_push_arbiter
package fifo_arb_pkg;
    typedef enum logic [1:0] {IDLE, PUSH, POP, ERR} arb_state_t;
    localparam int FIFO_DEPTH_DEF = 15;
    localparam int THR_W = 4;
    function automatic int rr_idx(int base, int off, int n);
        return (base + off) % n;
    endfunction
endpackage

// File: rtl/fifo_push_arbiter_if.sv
// fifo_push_arbiter_if: producer/consumer handshakes and FIFO pin bundle
interface fifo_push_arbiter_if #(parameter int NUM_REQ = 4, parameter int DATA_W = 8);
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic pop_req;
    logic pop_ack;
    logic fifo_en;
    logic fifo_push;
    logic fifo_pop;
    logic [DATA_W-1:0] fifo_din;
    logic fifo_overrun;
    logic fifo_underrun;
    modport master (
        output req_valid, req_data, pop_req, fifo_overrun, fifo_underrun,
        input  req_ready, pop_ack, fifo_en, fifo_push, fifo_pop, fifo_din
    );
    modport slave (
        input  req_valid, req_data, pop_req, fifo_overrun, fifo_underrun,
        output req_ready, pop_ack, fifo_en, fifo_push, fifo_pop, fifo_din
    );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr_i
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    input  logic         en_i,
    output logic [N-1:0] gnt_o,
    output logic [W-1:0] win_o
);
    always_comb begin
        int k;
        k = 0;
        gnt_o = '0;
        win_o = '0;
        // scan from farthest to nearest so the closest request to ptr_i wins
        for (int i = N - 1; i >= 0; i--) begin
            k = rr_idx(int'(ptr_i), i, N);
            if (en_i && req_i[k]) begin
                gnt_o = '0;
                gnt_o[k] = 1'b1;
                win_o = W'(k);
            end
        end
    end
endmodule

// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: round-robin push / pop sequencer in front of a simple FIFO.
// Optional FIFO_ARB_STATS_EN adds grant and stall counters.
module fifo_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH = FIFO_DEPTH_DEF,
    localparam int LW = $clog2(DEPTH + 1),
    localparam int GW = $clog2(NUM_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    fifo_push_arbiter_if.slave bus,
    input  logic             cfg_enable_i,
    input  logic [THR_W-1:0] cfg_threshold_i,
    input  logic             err_clr_i,
    output logic [THR_W-1:0] fifo_threshold_o,
    output logic [LW-1:0]    level_o,
    output logic [GW-1:0]    gnt_id_o,
    output logic             err_o
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0] stat_grants_o,
    output logic [15:0]           stat_stall_o
`endif
);
    arb_state_t state_q, state_d;
    logic [LW-1:0] level_q, level_d;
    logic [GW-1:0] ptr_q, ptr_d, gnt_q, win;
    logic [NUM_REQ-1:0] gnt;
    logic [DATA_W-1:0] din_q;
    logic [THR_W-1:0] thr_q;
    logic push_q, pop_q, en_q, err_q;
    logic in_err, err_in, pop_ok, push_ok, push_acc;

    assign in_err = state_q == ERR;
    assign err_in = bus.fifo_overrun | bus.fifo_underrun;
    assign pop_ok = cfg_enable_i & bus.pop_req & (level_q != '0) & ~in_err;
    assign push_ok = ~pop_ok & (level_q < LW'(DEPTH)) & cfg_enable_i & ~in_err;
    assign push_acc = |gnt;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req_i(bus.req_valid),
        .ptr_i(ptr_q),
        .en_i (push_ok),
        .gnt_o(gnt),
        .win_o(win)
    );

    always_comb begin
        state_d = err_in ? ERR : (in_err && !err_clr_i) ? ERR : pop_ok ? POP : push_acc ? PUSH : IDLE;
        level_d = pop_ok ? level_q - LW'(1) : push_acc ? level_q + LW'(1) : level_q;
        ptr_d = (win == GW'(NUM_REQ - 1)) ? '0 : win + GW'(1);
    end

    // level tracks accepts, so the op pins trail it by one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            level_q <= '0;
            ptr_q <= '0;
            gnt_q <= '0;
            din_q <= '0;
            thr_q <= '0;
            push_q <= 1'b0;
            pop_q <= 1'b0;
            en_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            push_q <= state_d == PUSH;
            pop_q <= state_d == POP;
            en_q <= (state_d == PUSH) || (state_d == POP);
            err_q <= state_d == ERR;
            level_q <= level_d;
            thr_q <= cfg_threshold_i;
            if (push_acc) begin
                ptr_q <= ptr_d;
                gnt_q <= win;
                din_q <= bus.req_data[win*DATA_W +: DATA_W];
            end
        end
    end

    assign bus.req_ready = gnt;
    assign bus.pop_ack = pop_ok;
    assign bus.fifo_en = en_q;
    assign bus.fifo_push = push_q;
    assign bus.fifo_pop = pop_q;
    assign bus.fifo_din = din_q;
    assign fifo_threshold_o = thr_q;
    assign level_o = level_q;
    assign gnt_id_o = gnt_q;
    assign err_o = err_q;

`ifdef FIFO_ARB_STATS_EN
    logic [NUM_REQ-1:0][15:0] grants_q;
    logic [15:0] stall_q;

    // a stall is a cycle where some producer waits and nobody is granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grants_q <= '0;
            stall_q <= '0;
        end else if (err_clr_i) begin
            grants_q <= '0;
            stall_q <= '0;
        end else begin
            if (push_acc && grants_q[win] != '1) grants_q[win] <= grants_q[win] + 16'd1;
            if ((|bus.req_valid) && !push_acc && stall_q != '1) stall_q <= stall_q + 16'd1;
        end
    end

    assign stat_grants_o = grants_q;
    assign stat_stall_o = stall_q;
`endif
endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb_fifo_push_arbiter: directed and random checks of fifo_push_arbiter against a behavioural model
module tb_fifo_push_arbiter;
    localparam int N = 4;
    localparam int DW = 8;
    localparam int D = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cfg_enable, err_clr;
    logic [3:0] cfg_thr, thr_o, level_o;
    logic [1:0] gnt_o;
    logic err_o;
`ifdef FIFO_ARB_STATS_EN
    logic [N*16-1:0] sg;
    logic [15:0] ss;
`endif

    always #5 clk = ~clk;

    fifo_push_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();

    fifo_push_arbiter #(.NUM_REQ(N), .DATA_W(DW), .DEPTH(D)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .cfg_enable_i(cfg_enable),
        .cfg_threshold_i(cfg_thr),
        .err_clr_i(err_clr),
        .fifo_threshold_o(thr_o),
        .level_o(level_o),
        .gnt_id_o(gnt_o),
        .err_o(err_o)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stat_grants_o(sg),
        .stat_stall_o(ss)
`endif
    );

    int total = 0, bad = 0;
    int m_level, m_ptr, m_gnt, m_din, m_thr, m_stall;
    int m_grants[N];
    bit m_err, m_push, m_pop;
    int obs_push = 0, obs_pop = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_level = 0; m_ptr = 0; m_gnt = 0; m_din = 0; m_thr = 0; m_stall = 0;
        m_err = 0; m_push = 0; m_pop = 0;
        for (int i = 0; i < N; i++) m_grants[i] = 0;
    endtask

    task automatic chk_regs();
        chk("fifo_push", bus.fifo_push, m_push);
        chk("fifo_pop", bus.fifo_pop, m_pop);
        chk("fifo_en", bus.fifo_en, m_push | m_pop);
        chk("fifo_din", bus.fifo_din, m_din);
        chk("gnt_id", gnt_o, m_gnt);
        chk("level", level_o, m_level);
        chk("err", err_o, m_err);
        chk("fifo_threshold", thr_o, m_thr);
    endtask

    // one clock: check handshakes, advance the model, check registered outputs
    task automatic cycle();
        bit pa, pok, found, accept, hold;
        int k, win, exp_ready;
        #1;
        pa = cfg_enable && bus.pop_req && m_level > 0 && !m_err;
        pok = !pa && m_level < D && cfg_enable && !m_err;
        found = 0; win = 0;
        for (int o = 0; o < N; o++) begin
            k = (m_ptr + o) % N;
            if (!found && bus.req_valid[k]) begin found = 1; win = k; end
        end
        accept = pok && found;
        exp_ready = accept ? (1 << win) : 0;
        chk("req_ready", bus.req_ready, exp_ready);
        chk("pop_ack", bus.pop_ack, pa);
        obs_push += int'(|bus.req_ready);
        obs_pop += int'(bus.pop_ack);
        if (err_clr) begin
            for (int i = 0; i < N; i++) m_grants[i] = 0;
            m_stall = 0;
        end else begin
            if (accept && m_grants[win] < 65535) m_grants[win]++;
            if (bus.req_valid != 0 && !accept && m_stall < 65535) m_stall++;
        end
        hold = bus.fifo_overrun || bus.fifo_underrun || (m_err && !err_clr);
        m_err = hold;
        m_push = !hold && accept;
        m_pop = !hold && pa;
        if (pa) m_level--;
        else if (accept) m_level++;
        if (accept) begin
            m_ptr = (win + 1) % N;
            m_gnt = win;
            m_din = int'(bus.req_data[win*DW +: DW]);
        end
        m_thr = int'(cfg_thr);
        @(posedge clk);
        #1;
        chk_regs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic idle_inputs();
        bus.req_valid = '0; bus.req_data = '0; bus.pop_req = 1'b0;
        bus.fifo_overrun = 1'b0; bus.fifo_underrun = 1'b0;
    endtask

`ifdef FIFO_ARB_STATS_EN
    task automatic chk_stats();
        for (int i = 0; i < N; i++) chk("stat_grants", sg[i*16 +: 16], m_grants[i]);
        chk("stat_stall", ss, m_stall);
    endtask
`endif

    initial begin
        int p0, q0;
        idle_inputs();
        cfg_enable = 1'b1; err_clr = 1'b0; cfg_thr = 4'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_regs();
        chk("reset_ready", bus.req_ready, 0);
        rst_n = 1'b1;

        // T1: all four producers, rotating grants
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            bus.req_data = $urandom;
            cfg_thr = 4'($urandom);
            cycle();
            chk("t1_gnt_seq", gnt_o, i % 4);
            chk("t1_push", bus.fifo_push, 1);
        end
        // T6: three stalled cycles with enable dropped
        cfg_enable = 1'b0;
        repeat (3) cycle();
`ifdef FIFO_ARB_STATS_EN
        for (int i = 0; i < N; i++) chk("t6_grants", sg[i*16 +: 16], 2);
        chk("t6_stall", ss, 3);
`endif
        cfg_enable = 1'b1;

        // T2: single producer fills the FIFO
        idle_inputs();
        do_reset();
        obs_push = 0;
        bus.req_valid = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            bus.req_data = $urandom;
            cycle();
        end
        chk("t2_accepts", obs_push, 15);
        chk("t2_level_full", level_o, 15);

        // T3: pop beats push until empty
        obs_pop = 0;
        bus.req_valid = 4'b1111;
        bus.pop_req = 1'b1;
        repeat (15) cycle();
        chk("t3_pops", obs_pop, 15);
        chk("t3_level_empty", level_o, 0);
        #1;
        chk("t3_pop_at_empty", bus.pop_ack, 0);
        cycle();

        // T4: underrun pulse, sticky error, recovery
        idle_inputs();
        bus.fifo_underrun = 1'b1;
        cycle();
        bus.fifo_underrun = 1'b0;
        chk("t4_err_set", err_o, 1);
        p0 = obs_push; q0 = obs_pop;
        bus.req_valid = 4'b1111;
        bus.pop_req = 1'b1;
        repeat (3) cycle();
        chk("t4_no_push", obs_push, p0);
        chk("t4_no_pop", obs_pop, q0);
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        bus.pop_req = 1'b0;
        chk("t4_err_clr", err_o, 0);
        cycle();
        chk("t4_resume", obs_push, p0 + 1);

        // random traffic, first fill-leaning then drain-leaning
        for (int i = 0; i < 300; i++) begin
            bus.req_valid = 4'($urandom);
            bus.req_data = $urandom;
            bus.pop_req = (i < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            cfg_enable = $urandom_range(0, 7) != 0;
            cfg_thr = 4'($urandom);
            err_clr = $urandom_range(0, 40) == 0;
            cycle();
        end
        err_clr = 1'b0;
        cfg_enable = 1'b1;
`ifdef FIFO_ARB_STATS_EN
        chk_stats();
`endif

        // T5: asynchronous reset between edges in the middle of a burst
        bus.pop_req = 1'b0;
        bus.req_valid = 4'b1111;
        do_reset();
        repeat (3) cycle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_push", bus.fifo_push, 0);
        chk("t5_en", bus.fifo_en, 0);
        chk("t5_level", level_o, 0);
        chk("t5_gnt", gnt_o, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.req_data = $urandom;
        cycle();
        chk("t5_first_gnt", gnt_o, 0);
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
